// File: rtl/seq_pattern_gen_pkg.sv
// seq_pattern_gen_pkg
//   Shared definitions for the serial pattern generator: FSM state encoding
//   and the active level of the synchronous reset (shared with the detector).
//   Optional feature macro: SEQ_GEN_PARITY_EN (adds the ST_PARITY state).
package seq_pattern_gen_pkg;

  // Level of the synchronous reset input that holds the design in reset.
  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef SEQ_GEN_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if
//   Request/stream bundle of the serial pattern generator.
//   start, pattern, rpt            : request side (driven by master)
//   ser_out, valid, frame_end,
//   busy, done                     : serial stream and status (driven by slave)
//   Modports: master (requester / observer), slave (generator).
interface seq_pattern_gen_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] rpt;
  logic             ser_out;
  logic             valid;
  logic             frame_end;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, rpt,
    input  ser_out, valid, frame_end, busy, done
  );

  modport slave (
    input  start, pattern, rpt,
    output ser_out, valid, frame_end, busy, done
  );

endinterface

// File: rtl/seq_pattern_gen_shift_reg.sv
// seq_shift_reg
//   WIDTH-bit parallel-load shift register, MSB out, shifting towards MSB.
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   load  : load din (has priority over shift)
//   shift : shift left by one, zero fill
//   din   : parallel load data
//   msb   : current most significant bit
module seq_shift_reg
  import seq_pattern_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clock) begin
    if (reset == RST_ACTIVE) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
//   Serial bit-pattern transmitter. Latches a WIDTH-bit pattern on an accepted
//   start and shifts it out MSB-first, repeating the frame rpt+1 times with no
//   gap between frames, then pulses done for one cycle.
//   Ports:
//     clock : rising-edge system clock
//     reset : synchronous, active-low
//     bus   : seq_pattern_gen_if.slave (start/pattern/rpt in;
//             ser_out/valid/frame_end/busy/done out)
//   Parameters: WIDTH (>=2), CNT_W, IDLE_LEVEL (ser_out when no bit is sent).
//   Optional macro SEQ_GEN_PARITY_EN: append an even-parity bit to every frame.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned CNT_W      = 4,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input logic               clock,
  input logic               reset,
  seq_pattern_gen_if.slave  bus
);

  localparam int unsigned BCW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [BCW-1:0]   bit_cnt;
  logic [CNT_W-1:0] frm_cnt;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] sr_din;
  logic             sr_msb;
  logic             sr_load;
  logic             sr_shift;
  logic             accept;
  logic             last_bit;
  logic             frame_bound;
  logic             more;

  assign accept   = (state == ST_IDLE) && bus.start;
  assign last_bit = (state == ST_SHIFT) && (bit_cnt == BCW'(WIDTH - 1));
  assign more     = (frm_cnt != '0);

`ifdef SEQ_GEN_PARITY_EN
  assign frame_bound = (state == ST_PARITY);
`else
  assign frame_bound = last_bit;
`endif

  // A new transfer loads from the inputs; later frames reload the latched copy.
  assign sr_load  = accept || (frame_bound && more);
  assign sr_shift = (state == ST_SHIFT) && !last_bit;
  assign sr_din   = accept ? bus.pattern : pat_q;

  seq_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clock (clock),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  always_ff @(posedge clock) begin
    if (reset == RST_ACTIVE) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) begin
`ifdef SEQ_GEN_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = more ? ST_SHIFT : ST_DONE;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PARITY: begin
        state_nxt = more ? ST_SHIFT : ST_DONE;
      end
`endif
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame counter holds the number of frames still to send after the current
  // one; it only decrements while non-zero, so it never wraps.
  always_ff @(posedge clock) begin
    if (reset == RST_ACTIVE) begin
      bit_cnt <= '0;
      frm_cnt <= '0;
      pat_q   <= '0;
    end else if (accept) begin
      bit_cnt <= '0;
      frm_cnt <= bus.rpt;
      pat_q   <= bus.pattern;
    end else begin
      if (state == ST_SHIFT) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + BCW'(1);
      end
      if (frame_bound && more) begin
        frm_cnt <= frm_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.ser_out   = IDLE_LEVEL;
    bus.valid     = 1'b0;
    bus.frame_end = 1'b0;
    bus.busy      = (state != ST_IDLE);
    bus.done      = 1'b0;
    case (state)
      ST_SHIFT: begin
        bus.ser_out = sr_msb;
        bus.valid   = 1'b1;
`ifndef SEQ_GEN_PARITY_EN
        bus.frame_end = last_bit;
`endif
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PARITY: begin
        bus.ser_out   = ^pat_q;
        bus.valid     = 1'b1;
        bus.frame_end = 1'b1;
      end
`endif
      ST_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen
//   Self-checking bench for seq_pattern_gen. Expected cycle-by-cycle output
//   vectors are produced by expanding each request into its bit stream.
//   Honours SEQ_GEN_PARITY_EN like the design.
module tb_seq_pattern_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 4;
  localparam logic        IDLE_LEVEL = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic ser;
    logic valid;
    logic fe;
    logic busy;
    logic done;
  } obs_t;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   hits;
  int   hits_fe;
  obs_t exp_q[$];

  seq_pattern_gen_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  seq_pattern_gen #(.WIDTH(W), .CNT_W(CW), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Expand one request into its expected output stream, plus the done
  // cycle and the trailing idle cycle.
  function automatic void build(input logic [W-1:0] pat, input int unsigned rpt);
    for (int unsigned f = 0; f <= rpt; f++) begin
      for (int b = W - 1; b >= 0; b--)
        exp_q.push_back(obs_t'{pat[b], 1'b1, (!PAR && b == 0), 1'b1, 1'b0});
      if (PAR)
        exp_q.push_back(obs_t'{^pat, 1'b1, 1'b1, 1'b1, 1'b0});
    end
    exp_q.push_back(obs_t'{IDLE_LEVEL, 1'b0, 1'b0, 1'b1, 1'b1});
    exp_q.push_back(obs_t'{IDLE_LEVEL, 1'b0, 1'b0, 1'b0, 1'b0});
  endfunction

  function automatic obs_t idle_obs();
    return obs_t'{IDLE_LEVEL, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  // Check the queued stream cycle by cycle at the falling edge. Unless hold
  // is set, start is dropped and pattern/rpt are scrambled after every check.
  task automatic run_q(input string tag, input bit hold, input int disturb_idx);
    obs_t       obs;
    logic [3:0] hist;
    hist    = '0;
    hits    = 0;
    hits_fe = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      obs = {bus.ser_out, bus.valid, bus.frame_end, bus.busy, bus.done};
      checks++;
      assert (obs === exp_q[i]) else begin
        errors++;
        $error("FAIL %s[%0d]: observed=%b expected=%b", tag, i, obs, exp_q[i]);
      end
      if (bus.valid === 1'b1) begin
        hist = {hist[2:0], bus.ser_out};
        if (hist == 4'b1001) begin
          hits++;
          if (bus.frame_end === 1'b1) hits_fe++;
        end
      end
      if (!hold) begin
        bus.start   = 1'b0;
        bus.pattern = W'($urandom);
        bus.rpt     = CW'($urandom);
      end
      if (i == disturb_idx) begin
        bus.start   = 1'b1;
        bus.pattern = '1;
      end
    end
    bus.start = 1'b0;
    exp_q.delete();
  endtask

  task automatic xfer(input string tag, input logic [W-1:0] pat,
                      input int unsigned rpt, input int disturb_idx);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.rpt     = CW'(rpt);
    build(pat, rpt);
    run_q(tag, 1'b0, disturb_idx);
  endtask

  initial begin
    obs_t obs;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.rpt     = '0;

    // Reset state, with start asserted to show it is ignored under reset.
    exp_q.push_back(idle_obs());
    exp_q.push_back(idle_obs());
    bus.start = 1'b1;
    run_q("reset", 1'b1, -1);
    reset = 1'b1;

    xfer("single", 4'b1001, 0, -1);
    xfer("b2b", 4'b1001, 1, -1);
    if (!PAR) begin
      checks++;
      assert (hits === 2) else begin
        errors++;
        $error("FAIL loopback_hits: observed=%0d expected=%0d", hits, 2);
      end
      checks++;
      assert (hits_fe === 2) else begin
        errors++;
        $error("FAIL loopback_on_frame_end: observed=%0d expected=%0d", hits_fe, 2);
      end
    end
    xfer("busy_ignore", 4'b1001, 0, 1);
    xfer("parity1011", 4'b1011, 0, -1);
    xfer("zeros", 4'b0000, 2, -1);
    xfer("ones", 4'b1111, 1, -1);
    xfer("rpt_max", 4'b0110, (1 << CW) - 1, -1);

    for (int k = 0; k < 6; k++)
      xfer("rand", W'($urandom), $urandom_range(0, 3), -1);

    // Start held high: two transfers with exactly one idle cycle between.
    bus.start   = 1'b1;
    bus.pattern = 4'b1101;
    bus.rpt     = '0;
    build(4'b1101, 0);
    build(4'b1101, 0);
    run_q("held_start", 1'b1, -1);

    // Reset during bit 3 aborts the frame with no done pulse.
    bus.start   = 1'b1;
    bus.pattern = 4'b1001;
    bus.rpt     = '0;
    build(4'b1001, 0);
    exp_q = exp_q[0:2];
    run_q("abort_pre", 1'b0, -1);
    reset = 1'b0;
    @(negedge clock);
    obs = {bus.ser_out, bus.valid, bus.frame_end, bus.busy, bus.done};
    checks++;
    assert (obs === idle_obs()) else begin
      errors++;
      $error("FAIL abort: observed=%b expected=%b", obs, idle_obs());
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(idle_obs());
    run_q("abort_post", 1'b0, -1);

    xfer("after_abort", 4'b1010, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
